// File: rtl/vga_source_selector_if.sv
// vga_source_selector_if: pixel-domain bundle between the vga_controller/visualizer side
// and the VGA DAC pins. The selector uses the slave view; whoever feeds it uses master.
interface vga_source_selector_if #(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 4,
    parameter int COLOR_W = 10
);
    logic [SEL_W-1:0]             i_mode_sel;
    logic                         i_frame_over;
    logic                         i_video_on;
    logic                         i_hsync;
    logic                         i_vsync;
    logic [NUM_SRC*3*COLOR_W-1:0] i_src_rgb;

    logic                         o_vga_hsync;
    logic                         o_vga_vsync;
    logic [COLOR_W-1:0]           o_vga_r;
    logic [COLOR_W-1:0]           o_vga_g;
    logic [COLOR_W-1:0]           o_vga_b;
    logic                         o_vga_blank_n;
    logic                         o_vga_sync_n;
    logic [SEL_W-1:0]             o_active_src;
    logic                         o_switch_busy;

    modport master (
        output i_mode_sel, i_frame_over, i_video_on, i_hsync, i_vsync, i_src_rgb,
        input  o_vga_hsync, o_vga_vsync, o_vga_r, o_vga_g, o_vga_b,
               o_vga_blank_n, o_vga_sync_n, o_active_src, o_switch_busy
    );

    modport slave (
        input  i_mode_sel, i_frame_over, i_video_on, i_hsync, i_vsync, i_src_rgb,
        output o_vga_hsync, o_vga_vsync, o_vga_r, o_vga_g, o_vga_b,
               o_vga_blank_n, o_vga_sync_n, o_active_src, o_switch_busy
    );
endinterface

// File: rtl/vga_source_selector.sv
// vga_source_selector: picks one of NUM_SRC colour streams for the VGA DAC.
// The mode switch is synchronised and debounced; the displayed source only changes on a
// frame boundary. Define VGA_SWITCH_MUTE_EN to blank MUTE_FRAMES whole frames after
// every switch (syncs keep running).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | displayed source matches the debounced request
// PENDING | request differs, waiting for the next frame boundary
// MUTE    | switched; colour forced black until the mute count expires
module vga_source_selector #(
    parameter int NUM_SRC         = 2,
    parameter int SEL_W           = 4,
    parameter int COLOR_W         = 10,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int MUTE_FRAMES     = 2,
    parameter int RESET_SRC       = 0
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
    vga_source_selector_if.slave bus
);
    localparam int                 PIX_W     = 3 * COLOR_W;
    localparam int                 DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SEL_W-1:0]   RST_SEL   = SEL_W'(RESET_SRC);
    // one bit wider so NUM_SRC == 2**SEL_W still compares correctly
    localparam logic [SEL_W:0]     NUM_SRC_X = (SEL_W + 1)'(NUM_SRC);
    localparam logic [DB_W-1:0]    DB_LOAD   = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef VGA_SWITCH_MUTE_EN
    localparam int                 MUTE_W    = $clog2(MUTE_FRAMES + 1);
    localparam logic [MUTE_W-1:0]  MUTE_LOAD = MUTE_W'(MUTE_FRAMES);
    localparam logic [MUTE_W-1:0]  MUTE_ONE  = MUTE_W'(1);
    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_MUTE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PENDING} state_t;
`endif

    logic [SEL_W-1:0] sel_meta;
    logic [SEL_W-1:0] sel_sync;
    logic [SEL_W-1:0] sel_cand;
    logic [SEL_W-1:0] req_src;
    logic [DB_W-1:0]  db_cnt;
    logic             sel_stable;
    logic             sel_valid;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic             busy_q;
    logic             muted;

`ifdef VGA_SWITCH_MUTE_EN
    logic [MUTE_W-1:0] mute_cnt_q, mute_cnt_d;
`endif

    logic [PIX_W-1:0] src_pix;
    logic [PIX_W-1:0] rgb_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             blank_n_q;

    // sel_cand trails sel_sync by one cycle; any difference is a change and restarts the timer
    assign sel_stable = (sel_sync == sel_cand) && (db_cnt == '0);
    assign sel_valid  = {1'b0, sel_cand} < NUM_SRC_X;

    // two-flop synchroniser and debounce down-counter
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            sel_meta <= RST_SEL;
            sel_sync <= RST_SEL;
            sel_cand <= RST_SEL;
            db_cnt   <= '0;
        end else begin
            sel_meta <= bus.i_mode_sel;
            sel_sync <= sel_meta;
            sel_cand <= sel_sync;
            if (sel_sync != sel_cand) begin
                db_cnt <= DB_LOAD;
            end else if (db_cnt != '0) begin
                db_cnt <= db_cnt - DB_W'(1);
            end
        end
    end

    // accept a debounced value only if it names an existing source
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            req_src <= RST_SEL;
        end else if (sel_stable && sel_valid) begin
            req_src <= sel_cand;
        end
    end

    // FSM state, displayed source and busy flag
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            active_q <= RST_SEL;
            busy_q   <= 1'b0;
`ifdef VGA_SWITCH_MUTE_EN
            mute_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            busy_q   <= (state_d != S_IDLE);
`ifdef VGA_SWITCH_MUTE_EN
            mute_cnt_q <= mute_cnt_d;
`endif
        end
    end

    // next-state logic; a request that reverts before the frame boundary cancels the switch
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
`ifdef VGA_SWITCH_MUTE_EN
        mute_cnt_d = mute_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_src != active_q) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (req_src == active_q) begin
                    state_d = S_IDLE;
                end else if (bus.i_frame_over) begin
                    active_d = req_src;
`ifdef VGA_SWITCH_MUTE_EN
                    state_d    = S_MUTE;
                    mute_cnt_d = MUTE_LOAD;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef VGA_SWITCH_MUTE_EN
            S_MUTE: begin
                if (bus.i_frame_over) begin
                    if (req_src != active_q) begin
                        active_d   = req_src;
                        mute_cnt_d = MUTE_LOAD;
                    end else begin
                        mute_cnt_d = mute_cnt_q - MUTE_W'(1);
                        if (mute_cnt_q == MUTE_ONE) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef VGA_SWITCH_MUTE_EN
    assign muted = (state_q == S_MUTE);
`else
    assign muted = 1'b0;
`endif

    // source mux driven by the displayed source
    always_comb begin
        src_pix = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (active_q == SEL_W'(k)) begin
                src_pix = bus.i_src_rgb[k*PIX_W +: PIX_W];
            end
        end
    end

    // single output register stage keeps colour, syncs and blank aligned
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hsync_q   <= bus.i_hsync;
            vsync_q   <= bus.i_vsync;
            blank_n_q <= bus.i_video_on;
            rgb_q     <= (bus.i_video_on && !muted) ? src_pix : '0;
        end
    end

    assign bus.o_vga_hsync   = hsync_q;
    assign bus.o_vga_vsync   = vsync_q;
    assign bus.o_vga_r       = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign bus.o_vga_g       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.o_vga_b       = rgb_q[COLOR_W-1:0];
    assign bus.o_vga_blank_n = blank_n_q;
    assign bus.o_vga_sync_n  = 1'b1;
    assign bus.o_active_src  = active_q;
    assign bus.o_switch_busy = busy_q;
endmodule

// File: tb/tb_vga_source_selector.sv
// tb_vga_source_selector: directed scenarios plus randomized switching, checked every cycle
// against a frame-level behavioural model of the selector.
module tb_vga_source_selector;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 4;
    localparam int COLOR_W = 10;
    localparam int DEB     = 4;
    localparam int MUTE    = 2;
    localparam int RST_SRC = 0;
    localparam int PIX_W   = 3 * COLOR_W;
`ifdef VGA_SWITCH_MUTE_EN
    localparam int EXP_MUTE = MUTE;
`else
    localparam int EXP_MUTE = 0;
`endif

    logic pixel_clk = 1'b0;
    logic reset;

    vga_source_selector_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .COLOR_W(COLOR_W)) vif ();

    vga_source_selector #(
        .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .COLOR_W(COLOR_W),
        .DEBOUNCE_CYCLES(DEB), .MUTE_FRAMES(MUTE), .RESET_SRC(RST_SRC)
    ) dut (
        .pixel_clk(pixel_clk),
        .reset(reset),
        .bus(vif)
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge pixel_clk);
            #1;
        end
    endtask

    function automatic logic [PIX_W-1:0] src_val(input int k);
        return {COLOR_W'(k*3+1), COLOR_W'(k*3+2), COLOR_W'(k*3+3)};
    endfunction

    // frame/pixel generator: short frames, fixed or random colours
    int frame_len = 12;
    int fcnt      = 0;
    bit rnd_rgb   = 1'b0;
    always @(negedge pixel_clk) begin
        fcnt = (fcnt >= frame_len - 1) ? 0 : fcnt + 1;
        vif.i_frame_over = (fcnt == frame_len - 1);
        if (rnd_rgb) begin
            vif.i_video_on = ($urandom_range(0, 3) != 0);
            vif.i_hsync    = 1'($urandom_range(0, 1));
            vif.i_vsync    = 1'($urandom_range(0, 1));
            for (int k = 0; k < NUM_SRC; k++) vif.i_src_rgb[k*PIX_W +: PIX_W] = PIX_W'($urandom);
        end else begin
            vif.i_video_on = (fcnt >= 1) && (fcnt < frame_len - 3);
            vif.i_hsync    = (fcnt != frame_len - 3);
            vif.i_vsync    = (fcnt != frame_len - 2);
            for (int k = 0; k < NUM_SRC; k++) vif.i_src_rgb[k*PIX_W +: PIX_W] = src_val(k);
        end
    end

    int fo_count = 0;
    always @(posedge pixel_clk) if (vif.i_frame_over === 1'b1) fo_count++;

    // behavioural model: select history window, frame-boundary switching, mute frame count
    int               hist[$];
    int               m_req, m_active, m_mute_left;
    bit               m_pending, m_stable;
    logic [PIX_W-1:0] m_pix;
    logic             e_hs, e_vs, e_blank, e_busy;
    logic [PIX_W-1:0] e_rgb;
    int               e_active;

    always @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < DEB + 3; i++) hist.push_back(RST_SRC);
            m_req = RST_SRC; m_active = RST_SRC; m_pending = 0; m_mute_left = 0;
            e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = '0; e_active = RST_SRC; e_busy = 0;
        end else begin
            e_hs    = vif.i_hsync;
            e_vs    = vif.i_vsync;
            e_blank = vif.i_video_on;
            m_pix   = vif.i_src_rgb[m_active*PIX_W +: PIX_W];
            e_rgb   = (vif.i_video_on && m_mute_left == 0) ? m_pix : '0;
            if (m_mute_left > 0) begin
                if (vif.i_frame_over) begin
                    if (m_req != m_active) begin
                        m_active = m_req; m_mute_left = EXP_MUTE;
                    end else begin
                        m_mute_left--;
                    end
                end
            end else if (m_pending) begin
                if (m_req == m_active) m_pending = 0;
                else if (vif.i_frame_over) begin
                    m_active = m_req; m_pending = 0; m_mute_left = EXP_MUTE;
                end
            end else if (m_req != m_active) begin
                m_pending = 1;
            end
            // req takes the synchronised value once DEB+1 consecutive samples agree
            hist.push_front(int'(vif.i_mode_sel));
            while (hist.size() > DEB + 3) void'(hist.pop_back());
            m_stable = 1;
            for (int i = 3; i <= DEB + 2; i++) if (hist[i] != hist[2]) m_stable = 0;
            if (m_stable && hist[2] < NUM_SRC) m_req = hist[2];
            e_active = m_active;
            e_busy   = m_pending || (m_mute_left > 0);
        end
    end

    bit chk_on = 1'b0;
    always @(negedge pixel_clk) begin
        if (chk_on) begin
            check("hsync",      32'(vif.o_vga_hsync),   32'(e_hs));
            check("vsync",      32'(vif.o_vga_vsync),   32'(e_vs));
            check("blank_n",    32'(vif.o_vga_blank_n), 32'(e_blank));
            check("rgb",        32'({vif.o_vga_r, vif.o_vga_g, vif.o_vga_b}), 32'(e_rgb));
            check("sync_n",     32'(vif.o_vga_sync_n),  32'd1);
            check("active_src", 32'(vif.o_active_src),  32'(e_active));
            check("busy",       32'(vif.o_switch_busy), 32'(e_busy));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, fo0, busy_hi, nz, fell;
        reset = 1'b1;
        vif.i_mode_sel   = '0;
        vif.i_frame_over = 1'b0;
        vif.i_video_on   = 1'b0;
        vif.i_hsync      = 1'b1;
        vif.i_vsync      = 1'b1;
        for (int s = 0; s < NUM_SRC; s++) vif.i_src_rgb[s*PIX_W +: PIX_W] = src_val(s);
        step(3);
        chk_on = 1'b1;

        check("rst_hsync",   32'(vif.o_vga_hsync),   32'd1);
        check("rst_vsync",   32'(vif.o_vga_vsync),   32'd1);
        check("rst_rgb",     32'({vif.o_vga_r, vif.o_vga_g, vif.o_vga_b}), 32'd0);
        check("rst_blank_n", 32'(vif.o_vga_blank_n), 32'd0);
        check("rst_sync_n",  32'(vif.o_vga_sync_n),  32'd1);
        check("rst_active",  32'(vif.o_active_src),  32'd0);
        check("rst_busy",    32'(vif.o_switch_busy), 32'd0);
        reset = 1'b0;

        k = 0;
        while (vif.o_vga_blank_n !== 1'b1 && k < 40) begin step(1); k++; end
        check("blank_seen_timeout", 32'(k < 40), 32'd1);
        check("src0_r", 32'(vif.o_vga_r), 32'd1);
        check("src0_g", 32'(vif.o_vga_g), 32'd2);
        check("src0_b", 32'(vif.o_vga_b), 32'd3);

        // short glitches must never reach req_src
        busy_hi = 0;
        vif.i_mode_sel = 4'd2;
        repeat (3) begin step(1); busy_hi += int'(vif.o_switch_busy); end
        vif.i_mode_sel = 4'd0;
        repeat (20) begin step(1); busy_hi += int'(vif.o_switch_busy); end
        check("bounce_busy_cycles", 32'(busy_hi), 32'd0);
        check("bounce_active",      32'(vif.o_active_src), 32'd0);

        // out-of-range select is ignored
        busy_hi = 0;
        vif.i_mode_sel = 4'd5;
        repeat (20) begin step(1); busy_hi += int'(vif.o_switch_busy); end
        check("oor_busy_cycles", 32'(busy_hi), 32'd0);
        check("oor_active",      32'(vif.o_active_src), 32'd0);
        vif.i_mode_sel = 4'd0;
        step(10);

        // 0 -> 1: req after 7 edges, busy one edge later
        vif.i_mode_sel = 4'd1;
        k = 0;
        do begin step(1); k++; end while (vif.o_switch_busy !== 1'b1 && k < 30);
        check("busy_rise_latency", 32'(k), 32'd8);
        check("active_held_pending", 32'(vif.o_active_src), 32'd0);
        k = 0;
        while (vif.o_active_src !== 4'd1 && k < 60) begin step(1); k++; end
        check("switch_to_1", 32'(vif.o_active_src), 32'd1);
        fo0 = fo_count; nz = 0; k = 0;
        while (vif.o_switch_busy === 1'b1 && k < 100) begin
            if ({vif.o_vga_r, vif.o_vga_g, vif.o_vga_b} != '0) nz++;
            step(1); k++;
        end
        check("mute_frames_after_switch", 32'(fo_count - fo0), 32'(EXP_MUTE));
        check("mute_black_pixels", 32'(nz), 32'd0);

        // request 2 while still muting after a switch to 0
        vif.i_mode_sel = 4'd0;
        k = 0;
        while (vif.o_active_src !== 4'd0 && k < 60) begin step(1); k++; end
        check("switch_to_0", 32'(vif.o_active_src), 32'd0);
        vif.i_mode_sel = 4'd2;
        fell = 0; k = 0;
        while (vif.o_active_src !== 4'd2 && k < 80) begin
            step(1); k++;
            if (vif.o_switch_busy !== 1'b1 && vif.o_active_src !== 4'd2) fell = 1;
        end
        check("switch_to_2", 32'(vif.o_active_src), 32'd2);
        check("busy_held_through_remute", 32'(fell), (EXP_MUTE > 0) ? 32'd0 : 32'd1);
        fo0 = fo_count; k = 0;
        while (vif.o_switch_busy === 1'b1 && k < 100) begin step(1); k++; end
        check("remute_frames", 32'(fo_count - fo0), 32'(EXP_MUTE));

        // reset in the middle of PENDING
        vif.i_mode_sel = 4'd1;
        k = 0;
        while (vif.o_switch_busy !== 1'b1 && k < 30) begin step(1); k++; end
        check("pending_before_reset", 32'(vif.o_active_src), 32'd2);
        reset = 1'b1;
        #1;
        check("reset_active_now", 32'(vif.o_active_src),  32'd0);
        check("reset_busy_now",   32'(vif.o_switch_busy), 32'd0);
        step(3);
        reset = 1'b0;
        k = 0;
        while (vif.o_active_src !== 4'd1 && k < 80) begin step(1); k++; end
        check("post_reset_switch", 32'(vif.o_active_src), 32'd1);
        step(40);

        // randomized switching, colours, frame lengths and occasional resets
        rnd_rgb = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 3));
                reset = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) frame_len = $urandom_range(8, 20);
            vif.i_mode_sel = SEL_W'($urandom_range(0, 6));
            step($urandom_range(1, 14));
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_source_selector.md
# vga_source_selector

Parametrised successor to the VGA top-level source multiplexer. It selects one of `NUM_SRC` visualizer colour streams (FFT, lock-in, future views) and drives the DE2 VGA DAC. The mode input is synchronised and debounced, source changes take effect only on a frame boundary, and the picture can optionally be muted for a few frames after each switch. It sits between the `vga_controller` plus visualizers and the physical VGA pins, entirely in the `pixel_clk` domain.

## Interface
- `NUM_SRC`, 2: number of colour sources, 2..16
- `SEL_W`, 4: width of the mode select
- `COLOR_W`, 10: bits per colour channel
- `DEBOUNCE_CYCLES`, 1024: cycles the select must stay stable before it is accepted, ≥1
- `MUTE_FRAMES`, 2: black frames after a switch, ≥1; only used with the mute feature
- `RESET_SRC`, 0: source active out of reset, < `NUM_SRC`

- `pixel_clk` in 1: the only clock
- `reset` in 1: asynchronous, active-high
- `i_mode_sel` in `SEL_W`: raw switch value, asynchronous
- `i_frame_over` in 1: one-cycle pulse at end of frame, from `vga_controller`
- `i_video_on` in 1: active-area flag
- `i_hsync`, `i_vsync` in 1: raw syncs, active-low
- `i_src_rgb` in `NUM_SRC*3*COLOR_W`: source k occupies bits [k*3*COLOR_W +: 3*COLOR_W], packed {R,G,B}
- `o_vga_hsync`, `o_vga_vsync` out 1: registered syncs
- `o_vga_r`, `o_vga_g`, `o_vga_b` out `COLOR_W`: registered colour
- `o_vga_blank_n` out 1: registered `i_video_on`
- `o_vga_sync_n` out 1: constant 1
- `o_active_src` out `SEL_W`: source currently displayed
- `o_switch_busy` out 1: high in PENDING or MUTE

## Operation
- Select path: 2-FF synchroniser, then a debouncer. A candidate value restarts the stability counter whenever it changes. Once it has been stable for `DEBOUNCE_CYCLES` consecutive cycles, `req_src` loads it on the following edge.
- Values ≥ `NUM_SRC` are never loaded. `req_src` holds its previous value.
- FSM:
  - IDLE: `req_src == o_active_src`. If `req_src` differs, go to PENDING.
  - PENDING: on `i_frame_over`, `o_active_src <= req_src`. Then go to MUTE with the counter loaded to `MUTE_FRAMES`, or to IDLE when mute is compiled out. If `req_src` returns to `o_active_src` before `i_frame_over`, go back to IDLE with no switch.
  - MUTE: on each `i_frame_over`:
    - if `req_src != o_active_src`: `o_active_src <= req_src` and the counter reloads;
    - else the counter decrements, and at 1 the FSM goes to IDLE.
- Colour output:
  - 0 when `i_video_on` = 0 or the FSM is in MUTE;
  - otherwise the slice of `i_src_rgb` selected by `o_active_src`.
- Reset values, asserted asynchronously:
  - `o_vga_hsync` = `o_vga_vsync` = 1;
  - RGB = 0, `o_vga_blank_n` = 0, `o_vga_sync_n` = 1;
  - `o_active_src` = `RESET_SRC`, `req_src` = `RESET_SRC`;
  - FSM in IDLE, `o_switch_busy` = 0, debounce and mute counters cleared.
- A reset in the middle of PENDING or MUTE abandons the switch. After release the block displays `RESET_SRC`, then re-debounces the current switch value.

## Timing
- Pixel path latency is exactly 1 cycle. RGB, syncs and blank_n are all registered from the same-cycle inputs, so they stay mutually aligned.
- A select edge propagates to `req_src` after 2 + `DEBOUNCE_CYCLES` + 1 cycles.
- `o_active_src` updates on the edge that samples `i_frame_over` = 1. The first pixel of the new frame uses the new source (or black in MUTE).
- If `req_src` changes in the same cycle as `i_frame_over`, the register value before that edge is used. The new request applies at the next frame boundary.
- `o_switch_busy` is registered together with the FSM state.

## Configuration
- `VGA_SWITCH_MUTE_EN` defined: MUTE state present; `MUTE_FRAMES` full black frames follow every switch, with syncs unaffected.
- Not defined: no MUTE state and no mute counter; PENDING goes directly to IDLE on `i_frame_over`.

## Test plan
Bench uses `NUM_SRC`=3, `DEBOUNCE_CYCLES`=4, `MUTE_FRAMES`=2, short frames.
- Hold reset, drive all sources non-zero → syncs=1, RGB=0, blank_n=0, `o_active_src`=0; release → source 0 colours appear 1 cycle after input, aligned with delayed syncs.
- Set `i_mode_sel` 0→1 → `req_src`=1 after 7 cycles; `o_active_src` stays 0 until the next `i_frame_over`, then becomes 1; with mute, 2 frames of RGB=0 follow and `o_switch_busy` falls after the second frame_over.
- Toggle `i_mode_sel` 0→2→0 with each value held 3 cycles → `req_src` never changes, `o_switch_busy` stays 0.
- Set `i_mode_sel`=5, out of range, held 20 cycles → `req_src` and `o_active_src` unchanged.
- During MUTE after a switch to 1, request 2 → next frame_over loads 2 and reloads the mute count to 2, giving 2 further black frames.
- Assert reset during PENDING → `o_active_src`=0 and busy=0 immediately; after release with switch at 1, the switch completes at the first frame_over following debounce.
